temp_operandos: RTL
===================

Name: temp_operandos

Overview:
- Parametrised successor to the single temp register between the data bus and the ULA.
- Captures bus words into a DEPTH-entry FIFO and stages them into two operand registers (A, B) presented to the ULA with a valid/ready handshake.
- Supports chaining: a ULA result can be written back as the next operand A.
- Drives the last captured word back onto the bus on a read strobe, mirroring the old io read-back.

Parameters:
WORD_W, 16, word width of bus, FIFO entries, operands and result
DEPTH, 4, FIFO entries; power of two, >= 2
CNT_W, $clog2(DEPTH+1), width of the count output (derived, not overridden)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous, active-low reset
data_in  input  WORD_W  bus value to capture
push  input  1  capture data_in into FIFO this cycle
le  input  1  read strobe: drive last captured word onto bus
data_out  output  WORD_W  last captured word (for bus tristate)
data_oe  output  1  bus drive enable, equals le
saida_ula_a  output  WORD_W  operand A to ULA
saida_ula_b  output  WORD_W  operand B to ULA
op_valid  output  1  A and B both valid
op_ready  input  1  ULA accepts the operand pair
resultado  input  WORD_W  ULA result for chaining
res_we  input  1  load resultado as next operand A
clear  input  1  synchronous flush of FIFO and operands
count  output  CNT_W  FIFO occupancy
full  output  1  count == DEPTH
empty  output  1  count == 0
erro  output  1  sticky: push dropped, or res_we dropped

Behaviour:
- Reset (rst_n low, asynchronous): FIFO pointers, count, data_out register, saida_ula_a/b, erro all 0; state VAZIO; op_valid 0; empty 1; full 0.
- Reset mid-operation discards all contents. No output glitches to non-reset values while rst_n is low.
- Accepted push: data_in written at the tail; the data_out register (ultimo) updated on the same edge. Occupancy visible the next cycle.
- FIFO pop is internal and driven only by the FSM.
- Push when full:
  - With a same-cycle pop: accepted, count unchanged.
  - Otherwise: dropped, ultimo unchanged, erro set.
- Pointers wrap modulo DEPTH. full and empty are derived from count.
- FSM states: VAZIO (no operand), TEM_A (A valid), PRONTO (A and B valid, op_valid=1).
  - VAZIO, res_we=1: A<=resultado, go to TEM_A, no pop. res_we has priority over the FIFO.
  - VAZIO, res_we=0, !empty: pop head into A, go to TEM_A.
  - TEM_A, !empty: pop head into B, go to PRONTO.
  - PRONTO, op_ready=1: go to VAZIO. A and B hold their values; no pop in this cycle.
  - res_we while in TEM_A or PRONTO: dropped, erro set. The FSM still takes its normal transition.
- op_valid is a registered decode of state == PRONTO. op_ready is ignored in other states.
- Latency: first push at edge k gives A at edge k+1 at the earliest. Back-to-back pushes at edges 0 and 1 give op_valid=1 after edge 2.
- clear (synchronous):
  - Empties the FIFO and sends the FSM to VAZIO; A/B are zeroed.
  - Has priority over push, pop and res_we in the same cycle.
  - Leaves erro and ultimo unchanged.
- erro clears only on reset.
- Bus read-back:
  - data_oe = le, combinational.
  - data_out = ultimo, registered, independent of the FSM.
  - A push and le in the same cycle return the pre-push value.
- All arithmetic is unsigned WORD_W. No width conversion; resultado is loaded unmodified.

Decomposition:
- Shared package (processador_pkg):
  - state enum {VAZIO, TEM_A, PRONTO}.
  - WORD_W default constant.
- One natural sub-module, fifo_sinc: synchronous FIFO parametrised by WORD_W/DEPTH.
  - Ports: push, pop, wdata, rdata (head, show-ahead), count, full, empty, clear.
- temp_operandos holds the FSM, operand registers, ultimo and erro.

Test Plan:
- Reset: hold rst_n=0 with push=1 and data_in=16'h1234 toggling -> all outputs 0, empty=1; after release, no capture until the first push.
- Basic pair: push 16'd100 at edge 0, 16'd7 at edge 1 -> after edge 2, op_valid=1, saida_ula_a=100, saida_ula_b=7, count=0. op_ready=1 for one cycle -> op_valid=0 next cycle.
- Full/overflow (DEPTH=4), op_ready held 0:
  - Push 6 words 1..6 -> A=1, B=2, FIFO holds 3,4,5,6 with count=4, full=1, erro=0.
  - 7th push of 7 -> dropped, erro=1, count stays 4.
  - Then op_ready=1 -> subsequent pairs (3,4),(5,6).
- Chaining: after consuming pair (5,3), pulse res_we with resultado=8 while FIFO holds 2 -> A=8, then B=2, op_valid=1; FIFO word 2 not lost.
- Simultaneous events:
  - clear with push=1 and res_we=1 -> empty, state VAZIO, erro unchanged, nothing captured.
  - Push when full with a same-cycle internal pop -> accepted, count unchanged.
- Read-back: push 16'hBEEF then assert le -> data_oe=1, data_out=16'hBEEF. le during a push of 16'h0001 -> data_out=16'hBEEF that cycle, 16'h0001 after.

Source files
------------

// File: rtl/processador_pkg.sv
// Shared types for the operand staging path between the data bus and the ULA.
package processador_pkg;

    localparam int WORD_W_PADRAO = 16;

    typedef enum logic [1:0] {
        VAZIO  = 2'd0,
        TEM_A  = 2'd1,
        PRONTO = 2'd2
    } estado_t;

endpackage

// File: rtl/temp_operandos_fifo_sinc.sv
// Synchronous show-ahead FIFO; the caller guarantees push only when there is room
// (or a same-cycle pop) and pop only when not empty.
module fifo_sinc #(
    parameter int WORD_W = 16,
    parameter int DEPTH  = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              push,
    input  logic              pop,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    logic [WORD_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;

    // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (clear) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            if (pop)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            count_r <= count_r + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Storage array, zeroed on reset so the head never shows stale data after power-up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
        end else if (push && !clear) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign count = count_r;
    assign full  = (count_r == CNT_W'(DEPTH));
    assign empty = (count_r == '0);

endmodule

// File: rtl/temp_operandos.sv
// Operand staging between the data bus and the ULA: FIFO of captured words feeding
// operand registers A/B, with result chaining and bus read-back of the last capture.
module temp_operandos
    import processador_pkg::*;
#(
    parameter int WORD_W = WORD_W_PADRAO,
    parameter int DEPTH  = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] data_in,
    input  logic              push,
    input  logic              le,
    output logic [WORD_W-1:0] data_out,
    output logic              data_oe,
    output logic [WORD_W-1:0] saida_ula_a,
    output logic [WORD_W-1:0] saida_ula_b,
    output logic              op_valid,
    input  logic              op_ready,
    input  logic [WORD_W-1:0] resultado,
    input  logic              res_we,
    input  logic              clear,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic              erro
);

    estado_t           estado_r, estado_s;
    logic [WORD_W-1:0] a_r, a_s, b_r, b_s;
    logic [WORD_W-1:0] ultimo_r;
    logic [WORD_W-1:0] head_s;
    logic              op_valid_r, erro_r;
    logic              pop_s, res_drop_s, push_acc_s, push_drop_s;
    logic              full_s, empty_s;

    fifo_sinc #(.WORD_W(WORD_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .push  (push_acc_s),
        .pop   (pop_s),
        .wdata (data_in),
        .rdata (head_s),
        .count (count),
        .full  (full_s),
        .empty (empty_s)
    );

    // Next state, operand loads and FIFO pop; clear overrides everything else.
    always_comb begin
        estado_s   = estado_r;
        a_s        = a_r;
        b_s        = b_r;
        pop_s      = 1'b0;
        res_drop_s = 1'b0;
        if (clear) begin
            estado_s = VAZIO;
            a_s      = '0;
            b_s      = '0;
        end else begin
            case (estado_r)
                VAZIO: begin
                    if (res_we) begin
                        a_s      = resultado;
                        estado_s = TEM_A;
                    end else if (!empty_s) begin
                        a_s      = head_s;
                        pop_s    = 1'b1;
                        estado_s = TEM_A;
                    end else begin
                        estado_s = VAZIO;
                    end
                end
                TEM_A: begin
                    res_drop_s = res_we;
                    if (!empty_s) begin
                        b_s      = head_s;
                        pop_s    = 1'b1;
                        estado_s = PRONTO;
                    end else begin
                        estado_s = TEM_A;
                    end
                end
                PRONTO: begin
                    res_drop_s = res_we;
                    if (op_ready) begin
                        estado_s = VAZIO;
                    end else begin
                        estado_s = PRONTO;
                    end
                end
                default: begin
                    estado_s = VAZIO;
                end
            endcase
        end
        // A full FIFO still accepts a word when the FSM frees a slot on the same edge.
        push_acc_s  = push && !clear && (!full_s || pop_s);
        push_drop_s = push && !clear && full_s && !pop_s;
    end

    // State, operands, bus read-back register and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_r   <= VAZIO;
            a_r        <= '0;
            b_r        <= '0;
            op_valid_r <= 1'b0;
            ultimo_r   <= '0;
            erro_r     <= 1'b0;
        end else begin
            estado_r   <= estado_s;
            a_r        <= a_s;
            b_r        <= b_s;
            op_valid_r <= (estado_s == PRONTO);
            if (push_acc_s) ultimo_r <= data_in;
            if (push_drop_s || res_drop_s) erro_r <= 1'b1;
        end
    end

    assign data_out    = ultimo_r;
    assign data_oe     = le;
    assign saida_ula_a = a_r;
    assign saida_ula_b = b_r;
    assign op_valid    = op_valid_r;
    assign full        = full_s;
    assign empty       = empty_s;
    assign erro        = erro_r;

endmodule
